// File: rtl/axi_rd_arb_pkg.sv
// Shared types and width helpers for the AXI read-channel arbiter.
// Optional statistics are enabled with AXI_RD_ARB_STATS_EN.
package axi_rd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    // {arid, araddr, arlen[7:0], arsize[2:0], arburst[1:0]}
    function automatic int ar_w(input int id_w, input int addr_w);
        return id_w + addr_w + 13;
    endfunction

    // {rid, rdata, rresp[1:0], rlast}
    function automatic int r_w(input int id_w, input int data_w);
        return id_w + data_w + 3;
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr.
// Used by axi_rd_arbiter (AXI_RD_ARB_STATS_EN has no effect here).
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    logic [IW-1:0] k;

    // Scan from the far end so the entry closest to ptr is written last.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        k       = '0;
        for (int i = N - 1; i >= 0; i--) begin
            k = IW'((int'(ptr) + i) % N);
            if (req[k]) begin
                gnt_idx = k;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read slave between NUM_M masters, one burst at a time.
// Define AXI_RD_ARB_STATS_EN to add per-master grant counters (grant_cnt).
module axi_rd_arbiter
    import axi_rd_arb_pkg::*;
#(
    parameter int NUM_M  = 2,
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    input  logic [NUM_M-1:0]                     m_arvalid,
    output logic [NUM_M-1:0]                     m_arready,
    input  logic [NUM_M*ar_w(ID_W,ADDR_W)-1:0]   m_ar_bus,
    output logic [NUM_M-1:0]                     m_rvalid,
    input  logic [NUM_M-1:0]                     m_rready,
    output logic [r_w(ID_W,DATA_W)-1:0]          m_r_bus,
    output logic                                 s_arvalid,
    input  logic                                 s_arready,
    output logic [ar_w(ID_W,ADDR_W)-1:0]         s_ar_bus,
    input  logic                                 s_rvalid,
    output logic                                 s_rready,
    input  logic [r_w(ID_W,DATA_W)-1:0]          s_r_bus,
    output logic [$clog2(NUM_M)-1:0]             owner,
    output logic                                 prot_err
`ifdef AXI_RD_ARB_STATS_EN
    ,output logic [NUM_M*16-1:0]                 grant_cnt
`endif
);

    localparam int AR_W  = ar_w(ID_W, ADDR_W);
    localparam int IDX_W = $clog2(NUM_M);

    state_t            state_q, state_d;
    logic [AR_W-1:0]   ar_q;
    logic [IDX_W-1:0]  owner_q;
    logic [IDX_W-1:0]  ptr_q;
    logic              perr_q;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_vld;
    logic [AR_W-1:0]   ar_in [NUM_M];

    for (genvar g = 0; g < NUM_M; g++) begin : g_ar
        assign ar_in[g] = m_ar_bus[g*AR_W +: AR_W];
    end

    rr_arbiter #(.N(NUM_M), .IW(IDX_W)) u_rr (
        .req     (m_arvalid),
        .ptr     (ptr_q),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // State, captured AR, owner, round-robin pointer and sticky error.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            ar_q    <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && gnt_vld) begin
                ar_q    <= ar_in[gnt_idx];
                owner_q <= gnt_idx;
                ptr_q   <= (gnt_idx == IDX_W'(NUM_M - 1)) ?
                           '0 : gnt_idx + IDX_W'(1);
            end
            if (s_rvalid && state_q != DATA)
                perr_q <= 1'b1;
        end
    end

    // Next state plus grant and R-channel routing.
    always_comb begin
        state_d   = state_q;
        m_arready = '0;
        m_rvalid  = '0;
        s_rready  = 1'b0;
        s_arvalid = 1'b0;
        m_r_bus   = '0;
        unique case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    m_arready[gnt_idx] = aresetn;
                    state_d            = ADDR;
                end
            end
            ADDR: begin
                s_arvalid = 1'b1;
                if (s_arready)
                    state_d = DATA;
            end
            DATA: begin
                m_r_bus           = s_r_bus;
                s_rready          = m_rready[owner_q];
                m_rvalid[owner_q] = s_rvalid;
                if (s_rvalid && s_rready && s_r_bus[0])
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_ar_bus = ar_q;
    assign owner    = owner_q;
    assign prot_err = perr_q;

`ifdef AXI_RD_ARB_STATS_EN
    for (genvar g = 0; g < NUM_M; g++) begin : g_cnt
        logic [15:0] cnt_q;

        // Saturating count of accepted addresses for master g.
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn)
                cnt_q <= '0;
            else if (state_q == ADDR && s_arready &&
                     owner_q == IDX_W'(g) && cnt_q != 16'hFFFF)
                cnt_q <= cnt_q + 16'd1;
        end

        assign grant_cnt[g*16 +: 16] = cnt_q;
    end
`endif

endmodule
